// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter with a registered broadcast stage.
// Tag 0 is reserved for "no producer" and is never placed on the bus.
module cdb_arbiter #(
    parameter int NREQ  = 4,
    parameter int TAGW  = 3,
    parameter int DATAW = 16
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*TAGW-1:0]  tag_in,
    input  logic [NREQ*DATAW-1:0] data_in,
    input  logic                  flush,
    output logic [NREQ-1:0]       gnt,
    output logic                  cdb_valid,
    output logic [TAGW-1:0]       cdb_tag,
    output logic [DATAW-1:0]      cdb_data,
    output logic [15:0]           bcast_count,
    output logic                  tag_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  zero_req;
    logic             found;
    logic [PW-1:0]    win_idx;

    logic             cdb_valid_q, cdb_valid_d;
    logic [TAGW-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATAW-1:0] cdb_data_q, cdb_data_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [15:0]      count_q, count_d;
    logic             tag_err_q, tag_err_d;

    always_comb begin
        elig     = '0;
        zero_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i]     = req[i] && (tag_in[i*TAGW +: TAGW] != '0);
            zero_req[i] = req[i] && (tag_in[i*TAGW +: TAGW] == '0);
        end
    end

    // Scan ptr, ptr+1, ... with wrap; first eligible unit wins.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && elig[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (CLR && !flush && found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        tag_err_d   = tag_err_q;
        if (flush) begin
            ptr_d = '0;
        end else begin
            if (found) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = tag_in[int'(win_idx)*TAGW +: TAGW];
                cdb_data_d  = data_in[int'(win_idx)*DATAW +: DATAW];
                ptr_d       = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            if (|zero_req) begin
                tag_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;
    assign bcast_count = count_q;
    assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference round-robin model predicts
// each grant and the broadcast that must appear one edge later.
module tb_cdb_arbiter;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [3:0]  req;
    logic [11:0] tag_in;
    logic [63:0] data_in;
    logic        flush;
    logic [3:0]  gnt;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [15:0] bcast_count;
    logic        tag_err;

    cdb_arbiter #(.NREQ(4), .TAGW(3), .DATAW(16)) dut (
        .CLK(CLK), .CLR(CLR), .req(req), .tag_in(tag_in),
        .data_in(data_in), .flush(flush), .gnt(gnt),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .bcast_count(bcast_count), .tag_err(tag_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          v;
        logic [2:0]  tag;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mptr = 0;
    int   mcount = 0;
    bit   merr = 1'b0;

    function automatic int model_win(input logic [3:0] r,
                                     input logic [11:0] t, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i] && t[i*3 +: 3] != 3'd0) return i;
        end
        return -1;
    endfunction

    // Reference model step: predicts grant, pushes expected broadcast.
    task automatic predict(output logic [3:0] eg);
        int   w;
        exp_t e;
        w = (flush || !CLR) ? -1 : model_win(req, tag_in, mptr);
        eg = 4'b0;
        e.v = 1'b0;
        e.tag = 3'd0;
        e.data = 16'd0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            e.v = 1'b1;
            e.tag = tag_in[w*3 +: 3];
            e.data = data_in[w*16 +: 16];
            mptr = (w + 1) % 4;
            if (mcount < 65535) mcount++;
        end else if (flush) begin
            mptr = 0;
        end
        if (!flush) begin
            for (int i = 0; i < 4; i++)
                if (req[i] && tag_in[i*3 +: 3] == 3'd0) merr = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic model_reset();
        mptr = 0;
        mcount = 0;
        merr = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        CLR = 1'b0;
        req = 4'b0;
        flush = 1'b0;
        #2;
        CLR = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        exp_t e;
        logic [3:0] eg;
        CLR = 1'b0;
        flush = 1'b0;
        req = 4'b1111;
        tag_in = {3'd4, 3'd3, 3'd2, 3'd1};
        data_in = 64'h4444_3333_2222_1111;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if (gnt !== 4'b0 || cdb_valid !== 1'b0 || bcast_count !== 16'd0
            || tag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: gnt=%b v=%b cnt=%0d err=%b want 0 0 0 0",
                     gnt, cdb_valid, bcast_count, tag_err);
        end
        @(negedge CLK);
        req = 4'b0;
        CLR = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            #2;
            predict(eg);
            vectors++;
            if (gnt !== eg) begin
                miscompares++;
                $display("FAIL idle gnt: got %b want %b", gnt, eg);
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            vectors++;
            if (cdb_valid !== e.v || bcast_count !== 16'(mcount)) begin
                miscompares++;
                $display("FAIL idle cdb: got v=%b cnt=%0d want v=%b cnt=%0d",
                         cdb_valid, bcast_count, e.v, mcount);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        logic [3:0] eg;
        logic [3:0] rv[3] = '{4'b0100, 4'b0000, 4'b1111};
        tag_in = {3'd4, 3'b011, 3'd2, 3'd1};
        data_in = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            req = rv[c];
            #2;
            predict(eg);
            vectors++;
            if (gnt !== eg) begin
                miscompares++;
                $display("FAIL single gnt c%0d: got %b want %b", c, gnt, eg);
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            vectors++;
            if (cdb_valid !== e.v || (e.v && (cdb_tag !== e.tag
                || cdb_data !== e.data)) || bcast_count !== 16'(mcount)) begin
                miscompares++;
                $display("FAIL single cdb c%0d: got v=%b t=%h d=%h n=%0d want v=%b t=%h d=%h n=%0d",
                         c, cdb_valid, cdb_tag, cdb_data, bcast_count,
                         e.v, e.tag, e.data, mcount);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [3:0] eg;
        do_reset();
        tag_in = {3'd4, 3'd3, 3'd2, 3'd1};
        data_in = 64'hDDDD_CCCC_BBBB_AAAA;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            req = 4'b1111;
            data_in[15:0] = 16'hA000 + 16'(c);
            #2;
            predict(eg);
            vectors++;
            if (gnt !== eg) begin
                miscompares++;
                $display("FAIL rr gnt c%0d: got %b want %b", c, gnt, eg);
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            vectors++;
            if (cdb_valid !== e.v || (e.v && (cdb_tag !== e.tag
                || cdb_data !== e.data)) || bcast_count !== 16'(mcount)) begin
                miscompares++;
                $display("FAIL rr cdb c%0d: got v=%b t=%h d=%h n=%0d want v=%b t=%h d=%h n=%0d",
                         c, cdb_valid, cdb_tag, cdb_data, bcast_count,
                         e.v, e.tag, e.data, mcount);
            end
        end
    endtask

    task automatic test_tag_zero();
        exp_t e;
        logic [3:0] eg;
        logic [3:0] rv[4] = '{4'b0011, 4'b0001, 4'b0001, 4'b0000};
        do_reset();
        tag_in = {3'd4, 3'd3, 3'b010, 3'b000};
        data_in = 64'h0000_0000_BEEF_DEAD;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            req = rv[c];
            #2;
            predict(eg);
            vectors++;
            if (gnt !== eg) begin
                miscompares++;
                $display("FAIL tag0 gnt c%0d: got %b want %b", c, gnt, eg);
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            vectors++;
            if (cdb_valid !== e.v || (e.v && (cdb_tag !== e.tag
                || cdb_data !== e.data)) || tag_err !== merr) begin
                miscompares++;
                $display("FAIL tag0 cdb c%0d: got v=%b t=%h err=%b want v=%b t=%h err=%b",
                         c, cdb_valid, cdb_tag, tag_err, e.v, e.tag, merr);
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [3:0] eg;
        logic [3:0] rv[5] = '{4'b0010, 4'b1010, 4'b1010, 4'b1000, 4'b1000};
        bit         fv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        tag_in = {3'd5, 3'd3, 3'd6, 3'd1};
        data_in = 64'h5555_3333_6666_1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            req = rv[c];
            flush = fv[c];
            #2;
            predict(eg);
            vectors++;
            if (gnt !== eg) begin
                miscompares++;
                $display("FAIL flush gnt c%0d: got %b want %b", c, gnt, eg);
            end
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            vectors++;
            if (cdb_valid !== e.v || (e.v && (cdb_tag !== e.tag
                || cdb_data !== e.data)) || bcast_count !== 16'(mcount)) begin
                miscompares++;
                $display("FAIL flush cdb c%0d: got v=%b t=%h n=%0d want v=%b t=%h n=%0d",
                         c, cdb_valid, cdb_tag, bcast_count, e.v, e.tag, mcount);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [3:0] eg;
        do_reset();
        tag_in = {3'd4, 3'd3, 3'd2, 3'd1};
        data_in = 64'h4444_3333_2222_1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            req = 4'b1111;
            #2;
            predict(eg);
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            vectors++;
            if (cdb_valid !== e.v || cdb_tag !== e.tag) begin
                miscompares++;
                $display("FAIL async pre c%0d: got v=%b t=%h want v=%b t=%h",
                         c, cdb_valid, cdb_tag, e.v, e.tag);
            end
        end
        #2;
        CLR = 1'b0;
        #1;
        vectors++;
        if (cdb_valid !== 1'b0 || gnt !== 4'b0 || bcast_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async drop: got v=%b gnt=%b n=%0d want 0 0000 0",
                     cdb_valid, gnt, bcast_count);
        end
        req = 4'b0;
        #2;
        CLR = 1'b1;
        model_reset();
        @(negedge CLK);
        req = 4'b1111;
        #2;
        predict(eg);
        vectors++;
        if (gnt !== eg) begin
            miscompares++;
            $display("FAIL async first gnt: got %b want %b", gnt, eg);
        end
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        vectors++;
        if (cdb_valid !== e.v || cdb_tag !== e.tag
            || bcast_count !== 16'(mcount)) begin
            miscompares++;
            $display("FAIL async first cdb: got v=%b t=%h n=%0d want v=%b t=%h n=%0d",
                     cdb_valid, cdb_tag, bcast_count, e.v, e.tag, mcount);
        end
    endtask

    initial begin
        CLR = 1'b0;
        req = 4'b0;
        flush = 1'b0;
        tag_in = '0;
        data_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_tag_zero();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the Common Data Bus among the functional units that complete operations for the reservation stations. Each cycle it selects at most one requesting unit using round-robin priority. It then broadcasts that unit's station tag and result on a registered CDB, which the reservation stations and the register file snoop to resolve dependencies. Tag 000 means "no producer" in the register file, so that tag is never broadcast.

Parameters:
NREQ, 4, number of requesting functional units (2..8)
TAGW, 3, reservation-station tag width
DATAW, 16, result data width

Ports:
CLK  in  1  clock; all state updates on rising edge
CLR  in  1  reset, asynchronous, active-low (CLR=0 resets)
req  in  NREQ  per-unit broadcast request; held high until granted
tag_in  in  NREQ*TAGW  packed station tags; unit i occupies bits [i*TAGW +: TAGW]
data_in  in  NREQ*DATAW  packed results; unit i occupies bits [i*DATAW +: DATAW]
flush  in  1  synchronous squash of all arbitration
gnt  out  NREQ  one-hot combinational grant for the current cycle
cdb_valid  out  1  registered broadcast valid
cdb_tag  out  TAGW  registered broadcast tag
cdb_data  out  DATAW  registered broadcast data
bcast_count  out  16  saturating count of broadcasts
tag_err  out  1  sticky flag: a request was seen with tag 0

Behaviour:
- Reset (CLR=0, asynchronous) clears:
  - cdb_valid=0, cdb_tag=0, cdb_data=0
  - round-robin pointer ptr=0
  - bcast_count=0, tag_err=0
  - gnt is forced to 0 for as long as CLR=0.
- Eligibility: unit i is eligible when req[i]=1 and tag_in[i]!=0.
- A request with tag 0 is never granted. Such a unit stays masked for as long as its tag is 0. Any cycle where this occurs sets tag_err=1, which is cleared only by reset.
- Selection: winner = first eligible unit scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. At most one gnt bit is high.
- gnt is combinational in the same cycle as the request (zero-cycle grant).
- The requester samples gnt at the same edge and then either drops req or presents its next result.
- On the rising edge in a cycle with a winner w and flush=0:
  - cdb_valid<=1, cdb_tag<=tag_in[w], cdb_data<=data_in[w]
  - ptr<=(w+1) mod NREQ
  - bcast_count<=bcast_count+1, saturating at 16'hFFFF
- Latency: request-to-broadcast is 1 cycle; the CDB holds each broadcast for exactly 1 cycle.
- On the rising edge in a cycle with no eligible unit: cdb_valid<=0. cdb_tag and cdb_data hold their previous values; they are don't-care when invalid. ptr is unchanged.
- Back-to-back broadcasts: one per cycle, with no bubble between them.
- Fairness: a unit that holds req high waits at most NREQ-1 grants before it wins.
- flush=1:
  - gnt=0 in that cycle
  - at the edge: cdb_valid<=0, ptr<=0
  - bcast_count and tag_err hold
- A broadcast already registered before flush rose still completes its single valid cycle.
- Simultaneous flush and requests: flush wins; no grant, and no count increment.
- Reset asserted mid-broadcast: cdb_valid drops immediately (asynchronously). No partial state survives.
- Reset deasserted: arbitration resumes on the first edge with CLR=1, starting from ptr=0.
- Inputs of units that are not granted are ignored. The arbiter does not buffer data; each requester holds its own result until granted.

Test Plan:
- Reset/idle:
  - CLR=0 with req=4'b1111 → gnt=0, cdb_valid=0, bcast_count=0.
  - Release CLR with req=0 → cdb_valid stays 0.
- Single requester: req=4'b0100, tag_in[2]=3'b011, data_in[2]=16'h1234 → gnt=4'b0100 in the same cycle. The next cycle shows cdb_valid=1, cdb_tag=011, cdb_data=1234 and bcast_count=1; after that, ptr=3.
- Round-robin: from reset, hold req=4'b1111 with tags 1,2,3,4 → grants occur in order 0,1,2,3,0, and cdb_tag runs 1,2,3,4,1 on consecutive cycles with no bubble.
- Tag-zero masking: req=4'b0011, tag_in[0]=0, tag_in[1]=3'b010 → unit 1 is granted, unit 0 never is, and tag_err=1 and stays high after req drops.
- Flush:
  - With req=4'b1000 and flush=1 for one cycle → gnt=0, and cdb_valid=0 the next cycle.
  - Once flush drops → unit 3 is granted, and the counter was not incremented during the flush.
- Async reset mid-stream: during continuous broadcasts, pull CLR low between edges → cdb_valid falls without waiting for an edge. After release, the first grant goes to unit 0 when req=4'b1111.
